// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline sequencing controller. The hazard unit
// and the debug CSR logic import the same package.
//   STATE_W          : width of the ctrl_state bus
//   RUN/MEM_WAIT/ERROR : state encodings as seen on ctrl_state
//   state_e          : enumerated controller state type
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] RUN      = 2'd0;
  localparam logic [STATE_W-1:0] MEM_WAIT = 2'd1;
  localparam logic [STATE_W-1:0] ERROR    = 2'd2;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN      = RUN,
    ST_MEM_WAIT = MEM_WAIT,
    ST_ERROR    = ERROR
  } state_e;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that stops at all-ones instead of wrapping, so long runs in the
// performance counters read as "at least this many" rather than garbage.
// Ports:
//   clk   : clock
//   rst   : asynchronous active-high reset, clears the count
//   inc   : count this cycle
//   count : current count value
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Pipeline sequencing controller for the 5-stage core. Drives the load enables
// and synchronous-clear (flush) inputs of the PC and the IF/ID, ID/EX, EX/MEM,
// MEM/WB registers, resolving load-use hazards, taken branches and data-memory
// wait states. Detects memory-ack timeouts and keeps saturating stall/flush
// counters for performance debug.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   hz_load_use         : ID instruction depends on a load in EX
//   br_taken            : EX resolves a taken branch/jump this cycle
//   mem_req, mem_ack    : MEM-stage data memory request / completion
//   *_load              : register load enables (PC and four stage registers)
//   *_flush             : register sync-clear inputs (bubble insert)
//   mem_err             : sticky ack-timeout error
//   ctrl_state          : current state (RUN=0, MEM_WAIT=1, ERROR=2)
//   stall_cnt           : cycles with pc_load=0 (saturating)
//   flush_cnt           : cycles with a branch flush issued (saturating)
// -----------------------------------------------------------------------------
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CW      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hz_load_use,
  input  logic               br_taken,
  input  logic               mem_req,
  input  logic               mem_ack,
  output logic               pc_load,
  output logic               ifid_load,
  output logic               idex_load,
  output logic               exmem_load,
  output logic               memwb_load,
  output logic               ifid_flush,
  output logic               idex_flush,
  output logic               exmem_flush,
  output logic               memwb_flush,
  output logic               mem_err,
  output logic [STATE_W-1:0] ctrl_state,
  output logic [CW-1:0]      stall_cnt,
  output logic [CW-1:0]      flush_cnt
);

  // Wide enough to hold TIMEOUT itself.
  localparam int WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TIMEOUT_W = WW'(TIMEOUT);

  state_e        state_q;
  state_e        state_d;
  logic [WW-1:0] wait_q;
  logic [WW-1:0] wait_d;

  logic hold;      // freeze everything, bubble into MEM/WB
  logic run;       // apply the normal branch / load-use / default rules
  logic br_flush;  // a branch flush is issued this cycle
  logic stall_inc;

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    hold        = 1'b0;
    run         = 1'b0;
    br_flush    = 1'b0;
    pc_load     = 1'b0;
    ifid_load   = 1'b0;
    idex_load   = 1'b0;
    exmem_load  = 1'b0;
    memwb_load  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;

    if (rst) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          // A memory stall freezes EX and ID, so any branch or hazard
          // request is simply seen again once the stall ends.
          if (mem_req && !mem_ack) begin
            hold    = 1'b1;
            state_d = ST_MEM_WAIT;
            wait_d  = WW'(1);
          end else begin
            run = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          // Ack is checked before the timeout, so a late ack still wins.
          if (mem_ack) begin
            run     = 1'b1;
            state_d = ST_RUN;
            wait_d  = '0;
          end else begin
            hold = 1'b1;
            if (wait_q == TIMEOUT_W) begin
              state_d = ST_ERROR;
            end else begin
              wait_d = wait_q + WW'(1);
            end
          end
        end
        ST_ERROR: begin
          hold = 1'b1;
        end
        default: begin
          hold    = 1'b1;
          state_d = ST_RUN;
          wait_d  = '0;
        end
      endcase

      if (hold) begin
        memwb_flush = 1'b1;
      end

      if (run) begin
        if (br_taken) begin
          // The dependent instruction is squashed, so load-use is moot.
          pc_load    = 1'b1;
          ifid_load  = 1'b1;
          idex_load  = 1'b1;
          exmem_load = 1'b1;
          memwb_load = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          br_flush   = 1'b1;
        end else if (hz_load_use) begin
          // Hold PC and IF/ID; the bubble enters EX through the ID/EX clear,
          // which dominates its load enable.
          idex_load  = 1'b1;
          exmem_load = 1'b1;
          memwb_load = 1'b1;
          idex_flush = 1'b1;
        end else begin
          pc_load    = 1'b1;
          ifid_load  = 1'b1;
          idex_load  = 1'b1;
          exmem_load = 1'b1;
          memwb_load = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // ERROR is only left through reset, so the state itself is the sticky flag.
  assign mem_err    = (state_q == ST_ERROR);
  assign ctrl_state = state_q;
  assign stall_inc  = !pc_load && !rst;

  sat_counter #(.WIDTH(CW)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CW)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (br_flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Self-checking bench for pipe_ctrl (TIMEOUT=4, CW=4). Each transaction pushes
// the expected outputs, derived from a small behavioural model of the
// controller, onto a scoreboard queue; the entry is popped and compared
// against the DUT at the following falling edge.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  localparam int TO = 4;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          hz_load_use;
  logic          br_taken;
  logic          mem_req;
  logic          mem_ack;
  logic          pc_load, ifid_load, idex_load, exmem_load, memwb_load;
  logic          ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic          mem_err;
  logic [1:0]    ctrl_state;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  pipe_ctrl #(.TIMEOUT(TO), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .hz_load_use (hz_load_use),
    .br_taken    (br_taken),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .pc_load     (pc_load),
    .ifid_load   (ifid_load),
    .idex_load   (idex_load),
    .exmem_load  (exmem_load),
    .memwb_load  (memwb_load),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .exmem_flush (exmem_flush),
    .memwb_flush (memwb_flush),
    .mem_err     (mem_err),
    .ctrl_state  (ctrl_state),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc, ifid, idex, exmem, memwb loads, ifid, idex, exmem, memwb flushes}
  logic [8:0] obs_ctl;
  assign obs_ctl = {pc_load, ifid_load, idex_load, exmem_load, memwb_load,
                    ifid_flush, idex_flush, exmem_flush, memwb_flush};

  typedef struct {
    string      tag;
    logic [8:0] ctl;
    logic [8:0] msk;
    logic [1:0] st;
    logic       err;
    int         sc;
    int         fc;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  int m_state = 0;
  int m_wait  = 0;
  int m_sc    = 0;
  int m_fc    = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the rising edge, push expected,
  // compare at the falling edge, then advance the model across the next edge.
  task automatic step(input string tag, input logic r, input logic h,
                      input logic b, input logic q, input logic a);
    exp_t       e;
    exp_t       got;
    logic [8:0] ctl;
    logic [8:0] msk;
    logic       brf;
    logic       runr;
    int         nstate;
    int         nwait;

    rst = r; hz_load_use = h; br_taken = b; mem_req = q; mem_ack = a;
    if (r) begin
      m_state = 0; m_wait = 0; m_sc = 0; m_fc = 0;
    end
    ctl = '0; msk = '1; brf = 1'b0; runr = 1'b0;
    nstate = m_state; nwait = m_wait;

    if (r) begin
      ctl = 9'b00000_1111;
    end else begin
      case (m_state)
        0: begin
          if (q && !a) begin
            ctl = 9'b00000_0001; nstate = 1; nwait = 1;
          end else begin
            runr = 1'b1;
          end
        end
        1: begin
          if (a) begin
            runr = 1'b1; nstate = 0; nwait = 0;
          end else begin
            ctl = 9'b00000_0001;
            if (m_wait == TO) nstate = 2;
            else nwait = m_wait + 1;
          end
        end
        default: ctl = 9'b00000_0001;
      endcase
      if (runr) begin
        if (b) begin
          ctl = 9'b11111_1100; brf = 1'b1;
        end else if (h) begin
          ctl = 9'b00011_0100; msk = 9'b110_111111;  // idex_load not pinned
        end else begin
          ctl = 9'b11111_0000;
        end
      end
    end

    e.tag = tag; e.ctl = ctl; e.msk = msk; e.st = 2'(m_state);
    e.err = (m_state == 2); e.sc = m_sc; e.fc = m_fc;
    sb.push_back(e);

    @(negedge clk);
    got = sb.pop_front();
    check_val({got.tag, ".ctl"}, 32'(obs_ctl & got.msk), 32'(got.ctl & got.msk));
    check_val({got.tag, ".state"}, 32'(ctrl_state), 32'(got.st));
    check_val({got.tag, ".mem_err"}, 32'(mem_err), 32'(got.err));
    check_val({got.tag, ".stall_cnt"}, 32'(stall_cnt), 32'(got.sc));
    check_val({got.tag, ".flush_cnt"}, 32'(flush_cnt), 32'(got.fc));
    $display("[%0t] %-10s rst=%b hz=%b br=%b req=%b ack=%b ctl=%b st=%0d err=%b sc=%0d fc=%0d",
             $time, tag, r, h, b, q, a, obs_ctl, ctrl_state, mem_err,
             stall_cnt, flush_cnt);

    if (!r) begin
      if (!ctl[8] && m_sc != 15) m_sc++;
      if (brf && m_fc != 15) m_fc++;
      m_state = nstate;
      m_wait  = nwait;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; hz_load_use = 1'b0; br_taken = 1'b0;
    mem_req = 1'b0; mem_ack = 1'b0;
    @(posedge clk);
    #1;

    // power-up reset, then a little traffic and a reset mid-run
    step("reset", 1, 0, 0, 0, 0);
    step("reset", 1, 0, 0, 0, 0);
    step("idle", 0, 0, 0, 0, 0);
    step("branch", 0, 0, 1, 0, 0);
    step("lu_pre", 0, 1, 0, 0, 0);
    step("idle", 0, 0, 0, 0, 0);
    step("rst_mid", 1, 0, 0, 0, 0);
    check_val("rst_mid.stall_zero", 32'(stall_cnt), 0);
    check_val("rst_mid.flush_zero", 32'(flush_cnt), 0);
    step("idle", 0, 0, 0, 0, 0);
    step("idle", 0, 0, 0, 0, 0);

    // load-use single-cycle pulse
    step("loaduse", 0, 1, 0, 0, 0);
    step("idle", 0, 0, 0, 0, 0);
    check_val("loaduse.stall_cnt", 32'(stall_cnt), 1);

    // branch together with load-use: branch wins, no stall
    step("br_lu", 0, 1, 1, 0, 0);
    step("idle", 0, 0, 0, 0, 0);
    check_val("br_lu.flush_cnt", 32'(flush_cnt), 1);
    check_val("br_lu.stall_cnt", 32'(stall_cnt), 1);

    // memory wait, 3 stall cycles, branch presented during the wait
    step("rst", 1, 0, 0, 0, 0);
    step("idle", 0, 0, 0, 0, 0);
    step("mw_req", 0, 0, 0, 1, 0);
    step("mw_wait", 0, 0, 1, 1, 0);
    step("mw_wait", 0, 0, 1, 1, 0);
    step("mw_ack", 0, 0, 1, 1, 1);
    step("idle", 0, 0, 0, 0, 0);
    check_val("mw.stall_cnt", 32'(stall_cnt), 3);
    check_val("mw.flush_cnt", 32'(flush_cnt), 1);

    // same-cycle ack is not a stall
    step("mem_fast", 0, 0, 0, 1, 1);

    // timeout into ERROR; a late ack must not recover
    step("rst", 1, 0, 0, 0, 0);
    step("idle", 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step("to_wait", 0, 0, 0, 1, 0);
    step("to_ack", 0, 0, 1, 1, 1);
    step("to_ack", 0, 0, 0, 1, 1);
    check_val("to.ctrl_state", 32'(ctrl_state), 2);
    check_val("to.mem_err", 32'(mem_err), 1);
    step("rst", 1, 0, 0, 0, 0);
    step("idle", 0, 0, 0, 0, 0);
    check_val("to.recover_state", 32'(ctrl_state), 0);

    // saturation of the 4-bit stall counter
    step("rst", 1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step("sat_lu", 0, 1, 0, 0, 0);
    step("idle", 0, 0, 0, 0, 0);
    check_val("sat.stall_cnt", 32'(stall_cnt), 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
